// File: rtl/sam_disk_pkg.sv
// Shared constants for the SAM Coupe floppy sector server: command/status
// word bit positions, default disk geometry and the server state encoding.
package sam_disk_pkg;

  localparam int DSR_SECTOR_LSB = 0;
  localparam int DSR_SECTOR_MSB = 4;
  localparam int DSR_TRACK_LSB  = 5;
  localparam int DSR_TRACK_MSB  = 11;
  localparam int DSR_SIDE       = 12;
  localparam int DSR_ACK        = 16;
  localparam int DSR_RD0        = 17;
  localparam int DSR_RD1        = 18;
  localparam int DSR_WR0        = 20;
  localparam int DSR_WR1        = 21;
  localparam int DSR_CMD_LSB    = 17;
  localparam int DSR_CMD_MSB    = 21;

  localparam int DCR_ERR  = 3;
  localparam int DCR_DONE = 4;

  localparam int SAM_TRACKS     = 80;
  localparam int SAM_SECTS      = 10;
  localparam int SAM_SECT_BYTES = 512;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    REQ  = 3'd2,
    XFER = 3'd3,
    DONE = 3'd4,
    FAIL = 3'd5,
    HOLD = 3'd6
  } state_t;

endpackage

// File: rtl/sam_chs_to_lba.sv
// Registered track/side/sector to image block address translation,
// with a flag for out-of-range geometry or an unmounted drive.
module sam_chs_to_lba
  import sam_disk_pkg::*;
#(
  parameter int TRACKS = SAM_TRACKS,
  parameter int SECTS  = SAM_SECTS
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        drive,
  input  logic [6:0]  track,
  input  logic        side,
  input  logic [4:0]  sector,
  input  logic [1:0]  img_mounted,
  input  logic [31:0] img_lba0,
  input  logic [31:0] img_lba1,
  output logic [31:0] lba,
  output logic        bad
);

  logic [31:0] base;
  logic [31:0] lba_calc;
  logic        bad_calc;

  always_comb begin
    base     = drive ? img_lba1 : img_lba0;
    lba_calc = base + {24'd0, track, side} * 32'(SECTS) + {27'd0, sector} - 32'd1;
    bad_calc = (sector == 5'd0)
            || ({27'd0, sector} > 32'(SECTS))
            || ({25'd0, track} >= 32'(TRACKS))
            || !img_mounted[drive];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lba <= '0;
      bad <= 1'b0;
    end else if (load) begin
      lba <= lba_calc;
      bad <= bad_calc;
    end
  end

endmodule

// File: rtl/sam_disk_sector_server.sv
// Sector server: decodes a controller command, runs one block transfer on the
// storage port while streaming bytes to/from the controller FIFOs, posts status.
module sam_disk_sector_server
  import sam_disk_pkg::*;
#(
  parameter int          TRACKS     = SAM_TRACKS,
  parameter int          SECTS      = SAM_SECTS,
  parameter int          SECT_BYTES = SAM_SECT_BYTES,
  parameter logic [23:0] TIMEOUT    = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] dsr,
  output logic [31:0] dcr,
  output logic [7:0]  dd0in,
  output logic        dd0inclk,
  input  logic [7:0]  dd0out,
  output logic        dd0outclk,
  input  logic [1:0]  img_mounted,
  input  logic [31:0] img_lba0,
  input  logic [31:0] img_lba1,
  output logic [31:0] blk_lba,
  output logic        blk_rd,
  output logic        blk_wr,
  input  logic        blk_ack,
  input  logic [7:0]  blk_rdata,
  input  logic        blk_rvalid,
  input  logic        blk_wreq,
  output logic [7:0]  blk_wdata,
  output logic        blk_wvalid,
  input  logic        blk_done,
  input  logic        blk_err
);

  state_t      state;
  logic        drv;
  logic        dir_wr;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [23:0] tmo;
  logic        done_q;
  logic        err_q;

  logic        cmd_go;
  logic        cmd_drv;
  logic        cmd_wr;
  logic        in_xfer;
  logic        below_full;
  logic        rd_byte;
  logic        wr_byte;
  logic        blk_evt;
  logic        tmo_hit;
  logic        lba_bad;

  logic        unused_dsr;
  assign unused_dsr = ^{dsr[31:22], dsr[15:13]};

  // Field latching happens inside the translator on the IDLE->CALC edge.
  sam_chs_to_lba #(
    .TRACKS (TRACKS),
    .SECTS  (SECTS)
  ) u_chs (
    .clk         (clk),
    .rstn        (rstn),
    .load        (state == IDLE && cmd_go),
    .drive       (cmd_drv),
    .track       (dsr[DSR_TRACK_MSB:DSR_TRACK_LSB]),
    .side        (dsr[DSR_SIDE]),
    .sector      (dsr[DSR_SECTOR_MSB:DSR_SECTOR_LSB]),
    .img_mounted (img_mounted),
    .img_lba0    (img_lba0),
    .img_lba1    (img_lba1),
    .lba         (blk_lba),
    .bad         (lba_bad)
  );

  always_comb begin
    cmd_go  = 1'b1;
    cmd_drv = 1'b0;
    cmd_wr  = 1'b0;
    if (dsr[DSR_RD0]) begin
      cmd_drv = 1'b0;
    end else if (dsr[DSR_RD1]) begin
      cmd_drv = 1'b1;
    end else if (dsr[DSR_WR0]) begin
      cmd_wr  = 1'b1;
    end else if (dsr[DSR_WR1]) begin
      cmd_drv = 1'b1;
      cmd_wr  = 1'b1;
    end else begin
      cmd_go  = 1'b0;
    end

    in_xfer    = (state == XFER);
    below_full = (cnt < 16'(SECT_BYTES));
    rd_byte    = in_xfer && !dir_wr && blk_rvalid && below_full;
    wr_byte    = in_xfer &&  dir_wr && blk_wreq   && below_full;
    // Byte of this cycle is counted before a simultaneous blk_done is judged.
    cnt_nxt    = cnt + {15'd0, rd_byte | wr_byte};
    blk_evt    = blk_ack || blk_rvalid || blk_wreq || blk_done;
    tmo_hit    = (tmo == TIMEOUT - 24'd1) && !blk_evt;

    dcr           = '0;
    dcr[DCR_DONE] = done_q;
    dcr[DCR_ERR]  = err_q;
  end

  assign dd0outclk = rstn && wr_byte;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      drv        <= 1'b0;
      dir_wr     <= 1'b0;
      cnt        <= '0;
      tmo        <= '0;
      blk_rd     <= 1'b0;
      blk_wr     <= 1'b0;
      dd0in      <= '0;
      dd0inclk   <= 1'b0;
      blk_wdata  <= '0;
      blk_wvalid <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dd0inclk   <= 1'b0;
      blk_wvalid <= 1'b0;

      if ((state == REQ || state == XFER) && !blk_evt)
        tmo <= tmo + 24'd1;
      else
        tmo <= '0;

      case (state)
        IDLE: begin
          if (cmd_go) begin
            drv    <= cmd_drv;
            dir_wr <= cmd_wr;
            state  <= CALC;
          end
        end
        CALC: begin
          if (lba_bad) begin
            state <= FAIL;
          end else begin
            blk_rd <= !dir_wr;
            blk_wr <= dir_wr;
            state  <= REQ;
          end
        end
        REQ: begin
          if (blk_ack) begin
            blk_rd <= 1'b0;
            blk_wr <= 1'b0;
            cnt    <= '0;
            state  <= XFER;
          end else if (tmo_hit) begin
            blk_rd <= 1'b0;
            blk_wr <= 1'b0;
            state  <= FAIL;
          end
        end
        XFER: begin
          if (rd_byte) begin
            dd0in    <= blk_rdata;
            dd0inclk <= 1'b1;
          end
          if (dir_wr && blk_wreq) begin
            blk_wvalid <= 1'b1;
            blk_wdata  <= wr_byte ? dd0out : 8'h00;
          end
          cnt <= cnt_nxt;
          if (blk_done)
            state <= (!blk_err && cnt_nxt == 16'(SECT_BYTES)) ? DONE : FAIL;
          else if (tmo_hit)
            state <= FAIL;
        end
        DONE: begin
          done_q <= 1'b1;
          err_q  <= 1'b0;
          state  <= HOLD;
        end
        FAIL: begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
          state  <= HOLD;
        end
        HOLD: begin
          if (dsr[DSR_ACK] && dsr[DSR_CMD_MSB:DSR_CMD_LSB] == '0) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_drv;
  assign unused_drv = drv;

endmodule

// File: tb/tb_sam_disk_sector_server.sv
// Randomized bench for sam_disk_sector_server: a behavioural block device and
// FIFO drive the DUT; expectations come from the sector-address arithmetic.
module tb_sam_disk_sector_server;

  localparam int NTRK = 80;
  localparam int NSEC = 10;
  localparam int NBYT = 512;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] dsr;
  logic [31:0] dcr;
  logic [7:0]  dd0in;
  logic        dd0inclk;
  logic [7:0]  dd0out;
  logic        dd0outclk;
  logic [1:0]  img_mounted;
  logic [31:0] img_lba0;
  logic [31:0] img_lba1;
  logic [31:0] blk_lba;
  logic        blk_rd;
  logic        blk_wr;
  logic        blk_ack;
  logic [7:0]  blk_rdata;
  logic        blk_rvalid;
  logic        blk_wreq;
  logic [7:0]  blk_wdata;
  logic        blk_wvalid;
  logic        blk_done;
  logic        blk_err;

  always #5 clk = ~clk;

  sam_disk_sector_server #(.TIMEOUT(24'd100)) dut (
    .clk(clk), .rstn(rstn), .dsr(dsr), .dcr(dcr),
    .dd0in(dd0in), .dd0inclk(dd0inclk), .dd0out(dd0out), .dd0outclk(dd0outclk),
    .img_mounted(img_mounted), .img_lba0(img_lba0), .img_lba1(img_lba1),
    .blk_lba(blk_lba), .blk_rd(blk_rd), .blk_wr(blk_wr), .blk_ack(blk_ack),
    .blk_rdata(blk_rdata), .blk_rvalid(blk_rvalid), .blk_wreq(blk_wreq),
    .blk_wdata(blk_wdata), .blk_wvalid(blk_wvalid),
    .blk_done(blk_done), .blk_err(blk_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller write FIFO (first-word-fall-through) and output monitors.
  logic [7:0] fifo [0:1023];
  logic [9:0] fifo_ptr = '0;
  int         pop_cnt = 0;
  int         req_cycles = 0;
  int         strobe_cnt = 0;
  logic [7:0] rd_q [$];
  logic [7:0] wd_q [$];

  assign dd0out = fifo[fifo_ptr];

  always @(posedge clk) if (dd0outclk) fifo_ptr <= fifo_ptr + 10'd1;

  always @(negedge clk) begin
    if (dd0inclk) rd_q.push_back(dd0in);
    if (blk_wvalid) wd_q.push_back(blk_wdata);
    if (dd0outclk) pop_cnt++;
    if (blk_rd || blk_wr) req_cycles++;
    if (dd0inclk || dd0outclk || blk_wvalid) strobe_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_hold(input logic [31:0] exp_dcr, input string tag);
    dsr = 32'h0021_0000;
    tick(); tick();
    check_eq({tag, "_hold_cmd"}, dcr, exp_dcr);
    dsr = 32'h0;
    tick();
    check_eq({tag, "_hold_noack"}, dcr, exp_dcr);
    dsr = 32'h0001_0000;
    tick();
    check_eq({tag, "_release"}, dcr, 32'h0);
    dsr = 32'h0;
    tick();
  endtask

  task automatic run_cmd(input logic [31:0] cmd_bits, input logic [6:0] trk, input logic sd,
                         input logic [4:0] sec, input logic [1:0] mnt,
                         input logic [31:0] l0, input logic [31:0] l1,
                         input int nbytes, input bit err, input bit sim_done, input string tag);
    int          cmd_pos [4] = '{17, 18, 20, 21};
    bit          found = 0;
    bit          mdrv = 0;
    bit          mwr = 0;
    bit          exp_bad;
    logic [31:0] exp_lba;
    logic [31:0] exp_dcr;
    logic [7:0]  exp_rd [$];
    int          rd_base, wd_base, pop_base, req_base, w, nerr, nexp;
    logic [9:0]  fbase;

    for (int i = 0; i < 4; i++)
      if (!found && cmd_bits[cmd_pos[i]]) begin
        found = 1;
        mdrv  = (i == 1 || i == 3);
        mwr   = (i >= 2);
      end
    exp_bad = (sec == 0) || (int'(sec) > NSEC) || (int'(trk) >= NTRK) || !mnt[mdrv];
    exp_lba = (mdrv ? l1 : l0) + ({25'd0, trk} * 32'd2 + {31'd0, sd}) * 32'd10
              + {27'd0, sec} - 32'd1;

    rd_base = rd_q.size(); wd_base = wd_q.size();
    pop_base = pop_cnt; req_base = req_cycles; fbase = fifo_ptr;
    img_mounted = mnt; img_lba0 = l0; img_lba1 = l1;
    dsr = cmd_bits;
    dsr[4:0] = sec; dsr[11:5] = trk; dsr[12] = sd;

    if (exp_bad) begin
      repeat (3) tick();
      check_eq({tag, "_noreq"}, req_cycles - req_base, 0);
      check_eq({tag, "_dcr"}, dcr, 32'h18);
      release_hold(32'h18, tag);
      return;
    end

    w = 0;
    while (!(blk_rd || blk_wr) && w < 10) begin tick(); w++; end
    check_eq({tag, "_req"}, {30'd0, blk_rd, blk_wr}, mwr ? 32'd1 : 32'd2);
    check_eq({tag, "_lba"}, blk_lba, exp_lba);
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    check_eq({tag, "_reqdrop"}, {30'd0, blk_rd, blk_wr}, 32'd0);

    for (int i = 0; i < nbytes; i++) begin
      if ($urandom_range(3) == 0) tick();
      if (mwr) blk_wreq = 1'b1;
      else begin
        blk_rvalid = 1'b1;
        blk_rdata  = 8'($urandom);
        exp_rd.push_back(blk_rdata);
      end
      if (sim_done && i == nbytes - 1) begin blk_done = 1'b1; blk_err = err; end
      tick();
      blk_rvalid = 1'b0; blk_wreq = 1'b0; blk_done = 1'b0; blk_err = 1'b0;
    end
    if (!(sim_done && nbytes > 0)) begin
      blk_done = 1'b1; blk_err = err; tick();
      blk_done = 1'b0; blk_err = 1'b0;
    end

    w = 0;
    while (!dcr[4] && w < 20) begin tick(); w++; end
    exp_dcr = (nbytes >= NBYT && !err) ? 32'h10 : 32'h18;
    check_eq({tag, "_dcr"}, dcr, exp_dcr);

    nerr = 0;
    if (mwr) begin
      nexp = (nbytes < NBYT) ? nbytes : NBYT;
      check_eq({tag, "_pops"}, pop_cnt - pop_base, nexp);
      check_eq({tag, "_wcount"}, wd_q.size() - wd_base, nbytes);
      for (int i = 0; i < nbytes && wd_base + i < wd_q.size(); i++)
        if (wd_q[wd_base + i] !== ((i < NBYT) ? fifo[fbase + 10'(i)] : 8'h00)) nerr++;
      check_eq({tag, "_wdata_errs"}, nerr, 0);
    end else begin
      check_eq({tag, "_rcount"}, rd_q.size() - rd_base, exp_rd.size());
      for (int i = 0; i < exp_rd.size() && rd_base + i < rd_q.size(); i++)
        if (rd_q[rd_base + i] !== exp_rd[i]) nerr++;
      check_eq({tag, "_rdata_errs"}, nerr, 0);
    end
    release_hold(exp_dcr, tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int snap, rsnap, w;
    for (int i = 0; i < 1024; i++) fifo[i] = 8'($urandom);
    rstn = 1'b0; dsr = '0; img_mounted = '0; img_lba0 = '0; img_lba1 = '0;
    blk_ack = 0; blk_rdata = '0; blk_rvalid = 0; blk_wreq = 0; blk_done = 0; blk_err = 0;
    repeat (3) tick();
    check_eq("rst_dcr", dcr, 32'h0);
    check_eq("rst_outs", {26'd0, blk_rd, blk_wr, dd0inclk, dd0outclk, blk_wvalid, 1'b0}, 32'h0);
    check_eq("rst_lba", blk_lba, 32'h0);
    rstn = 1'b1;
    tick();

    run_cmd(32'h0002_0000, 7'd4, 1'b1, 5'd3, 2'b11, 32'd1000, 32'd0, 512, 0, 0, "rd_t4s1s3");
    run_cmd(32'h0020_0000, 7'd0, 1'b0, 5'd1, 2'b11, 32'd0, 32'h200, 512, 0, 0, "wr_d1");
    run_cmd(32'h0002_0000, 7'd3, 1'b0, 5'd0, 2'b11, 32'd5, 32'd0, 512, 0, 0, "sec0");
    run_cmd(32'h0002_0000, 7'd3, 1'b0, 5'd11, 2'b11, 32'd5, 32'd0, 512, 0, 0, "sec11");
    run_cmd(32'h0002_0000, 7'd80, 1'b0, 5'd2, 2'b11, 32'd5, 32'd0, 512, 0, 0, "trk80");
    run_cmd(32'h0004_0000, 7'd1, 1'b0, 5'd2, 2'b01, 32'd5, 32'd9, 512, 0, 0, "unmounted");
    run_cmd(32'h0002_0000, 7'd79, 1'b1, 5'd10, 2'b11, 32'hFFFF_0000, 32'd0, 512, 0, 1, "edge_geom");
    run_cmd(32'h0002_0000, 7'd2, 1'b0, 5'd4, 2'b11, 32'd0, 32'd0, 300, 0, 0, "short300");
    run_cmd(32'h0002_0000, 7'd2, 1'b0, 5'd4, 2'b11, 32'd0, 32'd0, 512, 1, 0, "dev_err");
    run_cmd(32'h0010_0000, 7'd6, 1'b1, 5'd7, 2'b11, 32'd77, 32'd0, 514, 0, 0, "wr_extra");
    run_cmd(32'h0034_0000, 7'd5, 1'b0, 5'd5, 2'b10, 32'd0, 32'd3000, 512, 0, 0, "prio_rd1");
    run_cmd(32'h0030_0000, 7'd5, 1'b0, 5'd5, 2'b01, 32'd4000, 32'd0, 512, 0, 1, "prio_wr0");

    for (int n = 0; n < 12; n++) begin
      logic [31:0] cb;
      logic [6:0]  trk;
      int          nb;
      case ($urandom_range(3))
        0: cb = 32'h0002_0000;
        1: cb = 32'h0004_0000;
        2: cb = 32'h0010_0000;
        default: cb = 32'h0020_0000;
      endcase
      trk = ($urandom_range(3) == 0) ? 7'($urandom_range(75, 84)) : 7'($urandom_range(0, 79));
      nb  = ($urandom_range(4) == 0) ? int'($urandom_range(1, 511)) : NBYT;
      run_cmd(cb, trk, 1'($urandom), 5'($urandom_range(0, 11)),
              ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11,
              $urandom, $urandom, nb, ($urandom_range(5) == 0), 1'($urandom), $sformatf("rnd%0d", n));
    end

    // Block device never accepts the request.
    img_mounted = 2'b11; img_lba0 = 32'd50;
    dsr = 32'h0002_0000 | (32'd9 << 5) | 32'd2;
    w = 0;
    while (!blk_rd && w < 10) begin tick(); w++; end
    check_eq("tmo_req", {31'd0, blk_rd}, 32'd1);
    w = 0;
    while (!dcr[4] && w < 300) begin tick(); w++; end
    check_eq("tmo_latency_ok", {31'd0, (w >= 95 && w < 300)}, 32'd1);
    check_eq("tmo_rd_drop", {31'd0, blk_rd}, 32'd0);
    check_eq("tmo_dcr", dcr, 32'h18);
    release_hold(32'h18, "tmo");

    // Reset in the middle of a write transfer.
    dsr = 32'h0010_0000 | (32'd2 << 5) | 32'd5;
    w = 0;
    while (!blk_wr && w < 10) begin tick(); w++; end
    check_eq("rstx_req", {31'd0, blk_wr}, 32'd1);
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    for (int i = 0; i < 100; i++) begin blk_wreq = 1'b1; tick(); blk_wreq = 1'b0; end
    tick();
    snap = strobe_cnt;
    rsnap = req_cycles;
    rstn = 1'b0; blk_wreq = 1'b1;
    tick(); tick();
    blk_wreq = 1'b0; dsr = 32'h0;
    check_eq("rstx_strobes", strobe_cnt - snap, 0);
    check_eq("rstx_dcr", dcr, 32'h0);
    check_eq("rstx_lba", blk_lba, 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      blk_wreq = 1'($urandom); blk_rvalid = 1'($urandom); blk_done = (i == 15);
      tick();
    end
    blk_wreq = 0; blk_rvalid = 0; blk_done = 0;
    tick();
    check_eq("rstx_after_strobes", strobe_cnt - snap, 0);
    check_eq("rstx_after_req", req_cycles - rsnap, 0);
    check_eq("rstx_after_dcr", dcr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
